// File: rtl/mips_pkg.sv
// Shared encodings and the write-back buffer entry layout for the MIPS write-side datapath.
package mips_pkg;

    localparam logic [1:0]  LD_BYTE  = 2'd0;
    localparam logic [1:0]  LD_HALF  = 2'd1;
    localparam logic [1:0]  LD_WORD  = 2'd2;
    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] LINK_OFS = 32'd8;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Extracts and extends a byte/half/word from a raw memory word using the address low bits.
module wb_load_align
    import mips_pkg::*;
(
    input  logic [31:0] mdata_i,
    input  logic [1:0]  ldsz_i,
    input  logic        ldu_i,
    input  logic [1:0]  alo_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (alo_i)
            2'd0:    byte_sel = mdata_i[7:0];
            2'd1:    byte_sel = mdata_i[15:8];
            2'd2:    byte_sel = mdata_i[23:16];
            default: byte_sel = mdata_i[31:24];
        endcase
        half_sel = alo_i[1] ? mdata_i[31:16] : mdata_i[15:0];

        case (ldsz_i)
            LD_BYTE: data_o = {{24{~ldu_i & byte_sel[7]}}, byte_sel};
            LD_HALF: data_o = {{16{~ldu_i & half_sel[15]}}, half_sel};
            default: data_o = mdata_i;
        endcase
    end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-side controller: result buffer, registered write port and
// per-register pending-write scoreboard for RAW hazard detection in decode.
module reg_wb_ctrl
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_regwrite,
    input  logic        in_memtoreg,
    input  logic        in_link,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_mdata,
    input  logic [31:0] in_pc,
    input  logic [1:0]  in_ldsz,
    input  logic        in_ldu,
    input  logic [1:0]  in_alo,
    input  logic        hold,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic        iss_stall,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        busy1,
    output logic        busy2,
    output logic        regwrite,
    output logic [4:0]  wra,
    output logic [31:0] wd
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    wb_entry_t        fifo_q [DEPTH];
    wb_entry_t        head;
    wb_entry_t        in_entry;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full, push, pop;
    logic [31:0]      ld_data, wdata;
    logic             regwrite_q;
    logic [4:0]       wra_q;
    logic [31:0]      wd_q;
    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic             iss_en, ret_en;

    wb_load_align u_align (
        .mdata_i (in_mdata),
        .ldsz_i  (in_ldsz),
        .ldu_i   (in_ldu),
        .alo_i   (in_alo),
        .data_o  (ld_data)
    );

    always_comb begin
        if (in_link)          wdata = in_pc + LINK_OFS;
        else if (in_memtoreg) wdata = ld_data;
        else                  wdata = in_alu;
    end

    assign in_entry = {in_regwrite, in_rd, wdata};
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full && rst;
    assign push     = in_valid && in_ready;
    assign pop      = !hold && (count_q != '0);
    assign head     = fifo_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= in_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Writes to $0 still advance wra/wd but never assert the write enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regwrite_q <= 1'b0;
            wra_q      <= '0;
            wd_q       <= '0;
        end else if (pop) begin
            regwrite_q <= head.we && (head.rd != REG_ZERO);
            wra_q      <= head.rd;
            wd_q       <= head.data;
        end else begin
            regwrite_q <= 1'b0;
        end
    end

    assign regwrite = regwrite_q;
    assign wra      = wra_q;
    assign wd       = wd_q;

    assign iss_stall = iss_valid && (iss_rd != REG_ZERO) && (cnt_q[iss_rd] == CNT_MAX);
    assign iss_en    = iss_valid && (iss_rd != REG_ZERO) && !iss_stall;
    assign ret_en    = pop && head.we && (head.rd != REG_ZERO);

    // Issue and retire of the same register on one edge cancel; retire at zero saturates.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if ((iss_en && iss_rd == 5'(r)) && !(ret_en && head.rd == 5'(r)))
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            else if (!(iss_en && iss_rd == 5'(r)) && (ret_en && head.rd == 5'(r))
                     && cnt_q[r] != '0)
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < 32; r++) begin
            if (!rst) cnt_q[r] <= '0;
            else      cnt_q[r] <= cnt_d[r];
        end
    end

    assign busy1 = (rs1 != REG_ZERO) && (cnt_q[rs1] != '0);
    assign busy2 = (rs2 != REG_ZERO) && (cnt_q[rs2] != '0);

endmodule
